// File: rtl/sensor_scan_scheduler_if.sv
// ---------------------------------------------------------------------------
// sensor_scan_scheduler_if
//
// Purpose : Bundles every signal between the sensor scan scheduler and its
//           surroundings (sensor channels, the shared outlier engine and the
//           FPGA top level) into one interface.
//
// Modports:
//   master - the scheduler side (drives req_ready, eng_*, flag outputs)
//   slave  - the environment side (drives req_valid/req_data, engine
//            handshake and verdicts)
//
// Signals:
//   req_valid[NUM_CH]      channel i has a sample pending
//   req_data[NUM_CH*DW]    channel i sample at [i*DATA_W +: DATA_W]
//   req_ready[NUM_CH]      one-hot accept strobe
//   eng_valid/eng_data/eng_ch/eng_ready   sample handshake to the engine
//   res_valid/res_ch/res_outlier          verdict from the engine
//   outlier_flags/outlier_any/anomaly_pulse  per-channel verdict state
//   busy                   scheduler not idle
//   timeout_err            one-cycle pulse when a request is abandoned
// ---------------------------------------------------------------------------
interface sensor_scan_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_ready;

  logic                     eng_valid;
  logic [DATA_W-1:0]        eng_data;
  logic [CH_W-1:0]          eng_ch;
  logic                     eng_ready;

  logic                     res_valid;
  logic [CH_W-1:0]          res_ch;
  logic                     res_outlier;

  logic [NUM_CH-1:0]        outlier_flags;
  logic                     outlier_any;
  logic                     anomaly_pulse;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    input  req_valid, req_data, eng_ready, res_valid, res_ch, res_outlier,
    output req_ready, eng_valid, eng_data, eng_ch,
           outlier_flags, outlier_any, anomaly_pulse, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, eng_ready, res_valid, res_ch, res_outlier,
    input  req_ready, eng_valid, eng_data, eng_ch,
           outlier_flags, outlier_any, anomaly_pulse, busy, timeout_err
  );
endinterface

// File: rtl/sensor_scan_scheduler.sv
// ---------------------------------------------------------------------------
// sensor_scan_scheduler
//
// Purpose : Round-robin scheduler sharing one outlier-detection engine among
//           NUM_CH sensor channels. One sample is in flight at a time:
//           IDLE grants a channel, ISSUE presents the sample to the engine,
//           WAIT_RES waits for the matching verdict and folds it into the
//           per-channel outlier flags.
//
// Ports   :
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset (aborts any in-flight request)
//   bus  - sensor_scan_scheduler_if.master (see interface file)
//
// Parameters:
//   NUM_CH  (2..8)   number of channels
//   DATA_W           sample width
//   TIMEOUT (1..255) WAIT_RES cycle budget when the timeout is built
//
// Build option:
//   SCHED_TIMEOUT_EN - when defined, WAIT_RES abandons the request after
//                      TIMEOUT cycles and pulses timeout_err. When undefined,
//                      WAIT_RES waits forever and timeout_err is tied low.
// ---------------------------------------------------------------------------
module sensor_scan_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  sensor_scan_scheduler_if.master bus
);
  localparam int CH_W = $clog2(NUM_CH);

  // Elaboration-time parameter range guards.
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("sensor_scan_scheduler: NUM_CH must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("sensor_scan_scheduler: TIMEOUT must be 1..255");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CH_W-1:0]   eng_ch_q, eng_ch_d;
  logic [DATA_W-1:0] eng_data_q, eng_data_d;
  logic [NUM_CH-1:0] flags_q, flags_d;
  logic              any_q;
  logic              pulse_q;
  logic              tmo_err_q, tmo_err_d;
  logic [NUM_CH-1:0] req_ready_d;

`ifdef SCHED_TIMEOUT_EN
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
`endif

  // Per-channel sample slices of the flat request bus.
  logic [DATA_W-1:0] slice [NUM_CH];
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
    assign slice[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin search starting just after the last granted channel.
  logic              grant_found;
  logic [CH_W-1:0]   grant_ch;
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!grant_found && bus.req_valid[CH_W'(idx)]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(idx);
      end
    end
  end

  // Next-state and combinational outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    eng_ch_d     = eng_ch_q;
    eng_data_d   = eng_data_q;
    flags_d      = flags_q;
    tmo_err_d    = 1'b0;
    req_ready_d  = '0;
`ifdef SCHED_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_d  = NUM_CH'(1) << grant_ch;
          eng_ch_d     = grant_ch;
          last_grant_d = grant_ch;
          eng_data_d   = slice[grant_ch];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Verdicts arriving here are not ours yet; only eng_ready matters.
        if (bus.eng_ready) begin
          state_d = WAIT_RES;
`ifdef SCHED_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      WAIT_RES: begin
        if (bus.res_valid && (bus.res_ch == eng_ch_q)) begin
          // A matching verdict wins even in the last timeout cycle.
          flags_d[eng_ch_q] = bus.res_outlier;
          state_d           = IDLE;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      eng_ch_q     <= '0;
      eng_data_q   <= '0;
      flags_q      <= '0;
      any_q        <= 1'b0;
      pulse_q      <= 1'b0;
      tmo_err_q    <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      eng_ch_q     <= eng_ch_d;
      eng_data_q   <= eng_data_d;
      flags_q      <= flags_d;
      // Summary outputs follow the next-state flags so they change on the
      // same edge as outlier_flags; the pulse marks only 0->1 rises.
      any_q        <= |flags_d;
      pulse_q      <= |(flags_d & ~flags_q);
      tmo_err_q    <= tmo_err_d;
`ifdef SCHED_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign bus.req_ready     = req_ready_d;
  assign bus.eng_valid     = (state_q == ISSUE);
  assign bus.eng_data      = eng_data_q;
  assign bus.eng_ch        = eng_ch_q;
  assign bus.outlier_flags = flags_q;
  assign bus.outlier_any   = any_q;
  assign bus.anomaly_pulse = pulse_q;
  assign bus.busy          = (state_q != IDLE);
`ifdef SCHED_TIMEOUT_EN
  assign bus.timeout_err   = tmo_err_q;
`else
  assign bus.timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sensor_scan_scheduler
//
// Directed bench for sensor_scan_scheduler (NUM_CH=4, DATA_W=12, TIMEOUT=15).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (plus 1 time unit where a combinational output follows a fresh input).
// Channel samples: ch0=0x0F0, ch1=0x5A5, ch2=0x7FF, ch3=0x3C3.
// ---------------------------------------------------------------------------
module tb_sensor_scan_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sensor_scan_scheduler_if #(.NUM_CH(4), .DATA_W(12)) bus ();

  sensor_scan_scheduler #(.NUM_CH(4), .DATA_W(12), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] exp_data [4];

  // ---- stimulus helpers (no checking inside) ----
  // Called at a falling edge with the FSM idle; returns the req_ready seen
  // in the grant cycle and leaves the FSM in ISSUE at the next falling edge.
  task automatic grant(input logic [3:0] vmask, output logic [3:0] rdy);
    bus.req_valid = vmask;
    #1;
    rdy = bus.req_ready;
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic accept();
    bus.eng_ready = 1'b1;
    @(negedge clk);
    bus.eng_ready = 1'b0;
  endtask

  task automatic verdict(input logic [1:0] ch, input logic outl);
    bus.res_valid   = 1'b1;
    bus.res_ch      = ch;
    bus.res_outlier = outl;
    @(negedge clk);
    bus.res_valid   = 1'b0;
    $display("txn verdict ch=%0d outlier=%0d flags=%b", ch, outl, bus.outlier_flags);
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
    checks++; if (bus.eng_valid !== 1'b0) begin errors++; $display("FAIL reset_eng_valid got %b exp 0", bus.eng_valid); end
    checks++; if (bus.eng_data !== 12'h0) begin errors++; $display("FAIL reset_eng_data got %h exp 000", bus.eng_data); end
    checks++; if (bus.eng_ch !== 2'd0) begin errors++; $display("FAIL reset_eng_ch got %0d exp 0", bus.eng_ch); end
    checks++; if (bus.outlier_flags !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", bus.outlier_flags); end
    checks++; if (bus.outlier_any !== 1'b0) begin errors++; $display("FAIL reset_any got %b exp 0", bus.outlier_any); end
    checks++; if (bus.anomaly_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", bus.anomaly_pulse); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", bus.timeout_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // All four channels requesting, engine always ready, verdict one cycle
  // after accept: grants 0,1,2,3,0 on every third falling edge.
  task automatic test_round_robin();
    logic [1:0] ch;
    bus.req_valid = 4'hF;
    bus.eng_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      ch = 2'(n % 4);
      #1;
      checks++; if (bus.req_ready !== (4'b0001 << ch)) begin errors++; $display("FAIL rr_grant n=%0d got %b exp %b", n, bus.req_ready, 4'b0001 << ch); end
      @(negedge clk);
      checks++; if (bus.eng_valid !== 1'b1) begin errors++; $display("FAIL rr_eng_valid n=%0d got %b exp 1", n, bus.eng_valid); end
      checks++; if (bus.eng_ch !== ch) begin errors++; $display("FAIL rr_eng_ch n=%0d got %0d exp %0d", n, bus.eng_ch, ch); end
      checks++; if (bus.eng_data !== exp_data[ch]) begin errors++; $display("FAIL rr_eng_data n=%0d got %h exp %h", n, bus.eng_data, exp_data[ch]); end
      checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rr_ready_issue n=%0d got %b exp 0000", n, bus.req_ready); end
      @(negedge clk);
      checks++; if (bus.eng_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rr_wait n=%0d got valid=%b busy=%b exp valid=0 busy=1", n, bus.eng_valid, bus.busy); end
      checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rr_ready_wait n=%0d got %b exp 0000", n, bus.req_ready); end
      verdict(ch, 1'b0);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle n=%0d got busy=%b exp 0", n, bus.busy); end
    end
    bus.req_valid = '0;
    bus.eng_ready = 1'b0;
    checks++; if (bus.outlier_flags !== 4'b0) begin errors++; $display("FAIL rr_flags got %b exp 0000", bus.outlier_flags); end
  endtask

  task automatic test_outlier_flag();
    logic [3:0] rdy;
    // last grant was ch0; only ch2 requests
    grant(4'b0100, rdy);
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL of_grant got %b exp 0100", rdy); end
    checks++; if (bus.eng_data !== 12'h7FF || bus.eng_ch !== 2'd2) begin errors++; $display("FAIL of_sample got %h/%0d exp 7ff/2", bus.eng_data, bus.eng_ch); end
    accept();
    verdict(2'd2, 1'b1);
    checks++; if (bus.outlier_flags !== 4'b0100) begin errors++; $display("FAIL of_flags_rise got %b exp 0100", bus.outlier_flags); end
    checks++; if (bus.outlier_any !== 1'b1) begin errors++; $display("FAIL of_any_rise got %b exp 1", bus.outlier_any); end
    checks++; if (bus.anomaly_pulse !== 1'b1) begin errors++; $display("FAIL of_pulse_rise got %b exp 1", bus.anomaly_pulse); end
    @(negedge clk);
    checks++; if (bus.anomaly_pulse !== 1'b0) begin errors++; $display("FAIL of_pulse_width got %b exp 0", bus.anomaly_pulse); end
    checks++; if (bus.outlier_flags !== 4'b0100) begin errors++; $display("FAIL of_flags_hold got %b exp 0100", bus.outlier_flags); end
    // repeat verdict 1 -> 1: no pulse
    grant(4'b0100, rdy);
    accept();
    verdict(2'd2, 1'b1);
    checks++; if (bus.anomaly_pulse !== 1'b0 || bus.outlier_flags !== 4'b0100) begin errors++; $display("FAIL of_repeat got pulse=%b flags=%b exp pulse=0 flags=0100", bus.anomaly_pulse, bus.outlier_flags); end
    // verdict 0 clears the flag, still no pulse
    grant(4'b0100, rdy);
    accept();
    verdict(2'd2, 1'b0);
    checks++; if (bus.outlier_flags !== 4'b0 || bus.outlier_any !== 1'b0 || bus.anomaly_pulse !== 1'b0) begin errors++; $display("FAIL of_clear got flags=%b any=%b pulse=%b exp 0000/0/0", bus.outlier_flags, bus.outlier_any, bus.anomaly_pulse); end
  endtask

  // Engine stalls 5 cycles on ch1, a verdict arriving with eng_ready is
  // dropped, a mismatched tag is ignored, then ch1's own verdict lands.
  task automatic test_stall_and_tags();
    logic [3:0] rdy;
    grant(4'b0010, rdy);
    checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL st_grant got %b exp 0010", rdy); end
    bus.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++; if (bus.eng_valid !== 1'b1 || bus.eng_data !== 12'h5A5 || bus.eng_ch !== 2'd1) begin errors++; $display("FAIL st_hold n=%0d got %b/%h/%0d exp 1/5a5/1", n, bus.eng_valid, bus.eng_data, bus.eng_ch); end
      checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL st_ready n=%0d got %b exp 0000", n, bus.req_ready); end
      @(negedge clk);
    end
    bus.req_valid   = '0;
    bus.res_valid   = 1'b1;
    bus.res_ch      = 2'd1;
    bus.res_outlier = 1'b1;
    accept();
    bus.res_valid   = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.outlier_flags !== 4'b0) begin errors++; $display("FAIL st_issue_verdict got busy=%b flags=%b exp 1/0000", bus.busy, bus.outlier_flags); end
    verdict(2'd3, 1'b1);
    checks++; if (bus.busy !== 1'b1 || bus.outlier_flags !== 4'b0) begin errors++; $display("FAIL st_bad_tag got busy=%b flags=%b exp 1/0000", bus.busy, bus.outlier_flags); end
    verdict(2'd1, 1'b1);
    checks++; if (bus.busy !== 1'b0 || bus.outlier_flags !== 4'b0010 || bus.anomaly_pulse !== 1'b1) begin errors++; $display("FAIL st_good_tag got busy=%b flags=%b pulse=%b exp 0/0010/1", bus.busy, bus.outlier_flags, bus.anomaly_pulse); end
  endtask

  task automatic test_timeout();
    logic [3:0] rdy;
    grant(4'hF, rdy);
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL to_grant got %b exp 0100", rdy); end
    accept();
`ifdef SCHED_TIMEOUT_EN
    for (int n = 1; n < 15; n++) begin
      @(negedge clk);
      checks++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL to_early n=%0d got err=%b busy=%b exp 0/1", n, bus.timeout_err, bus.busy); end
    end
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL to_fire got err=%b busy=%b exp 1/0", bus.timeout_err, bus.busy); end
    checks++; if (bus.outlier_flags !== 4'b0010) begin errors++; $display("FAIL to_flags got %b exp 0010", bus.outlier_flags); end
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %b exp 0", bus.timeout_err); end
`else
    repeat (20) @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL to_wait_forever got err=%b busy=%b exp 0/1", bus.timeout_err, bus.busy); end
    verdict(2'd2, 1'b0);
    checks++; if (bus.outlier_flags !== 4'b0010 || bus.busy !== 1'b0) begin errors++; $display("FAIL to_late_verdict got flags=%b busy=%b exp 0010/0", bus.outlier_flags, bus.busy); end
`endif
    grant(4'hF, rdy);
    checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL to_next_grant got %b exp 1000", rdy); end
    accept();
  endtask

  // Entered with ch3 in WAIT_RES and flag 1 set.
  task automatic test_reset_midflight();
    logic [3:0] rdy;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.eng_valid !== 1'b0 || bus.eng_ch !== 2'd0 || bus.eng_data !== 12'h0) begin errors++; $display("FAIL mr_engine got busy=%b valid=%b ch=%0d data=%h exp 0/0/0/000", bus.busy, bus.eng_valid, bus.eng_ch, bus.eng_data); end
    checks++; if (bus.outlier_flags !== 4'b0 || bus.outlier_any !== 1'b0 || bus.anomaly_pulse !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL mr_flags got %b/%b/%b/%b exp 0000/0/0/0", bus.outlier_flags, bus.outlier_any, bus.anomaly_pulse, bus.timeout_err); end
    rst = 1'b0;
    @(negedge clk);
    grant(4'hF, rdy);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL mr_first_grant got %b exp 0001", rdy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_data[0] = 12'h0F0;
    exp_data[1] = 12'h5A5;
    exp_data[2] = 12'h7FF;
    exp_data[3] = 12'h3C3;
    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.req_data    = {12'h3C3, 12'h7FF, 12'h5A5, 12'h0F0};
    bus.eng_ready   = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_ch      = '0;
    bus.res_outlier = 1'b0;

    test_reset();
    test_round_robin();
    test_outlier_flag();
    test_stall_and_tags();
    test_timeout();
    test_reset_midflight();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
